// File: rtl/dnc_pkg.sv
// Shared definitions for the DNC write-head input sequencer: FSM states,
// fill constants and scalar capture order.
package dnc_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    K_LOAD = 3'd1,
    K_WAIT = 3'd2,
    E_LOAD = 3'd3,
    E_WAIT = 3'd4,
    V_LOAD = 3'd5,
    V_WAIT = 3'd6,
    S_LOAD = 3'd7
  } state_t;

  localparam logic [63:0] ZERO_CONTROL = '0;
  localparam logic [63:0] ONE_CONTROL  = 64'd1;
  localparam logic [63:0] ZERO_DATA    = '0;

  localparam logic [1:0] BETA_IDX = 2'd0;
  localparam logic [1:0] GA_IDX   = 2'd1;
  localparam logic [1:0] GW_IDX   = 2'd2;

  function automatic logic is_load(input state_t s);
    return (s == K_LOAD) || (s == E_LOAD) || (s == V_LOAD) || (s == S_LOAD);
  endfunction

endpackage

// File: rtl/accelerator_vector_phase_counter.sv
// Element counter shared by the three vector phases and the scalar phase;
// o_last flags that the current count equals the phase limit.
module accelerator_vector_phase_counter
  import dnc_pkg::*;
#(
  parameter int unsigned CONTROL_SIZE = 64
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_clear,
  input  logic                    i_inc,
  input  logic [CONTROL_SIZE-1:0] i_limit,
  output logic [CONTROL_SIZE-1:0] o_count,
  output logic                    o_last
);

  logic [CONTROL_SIZE-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= CONTROL_SIZE'(ZERO_CONTROL);
    end else if (i_clear) begin
      r_count <= CONTROL_SIZE'(ZERO_CONTROL);
    end else if (i_inc) begin
      r_count <= r_count + CONTROL_SIZE'(ONE_CONTROL);
    end
  end

  assign o_count = r_count;
  assign o_last  = (r_count == i_limit);

endmodule

// File: rtl/accelerator_write_heads_sequencer.sv
// Demultiplexes one controller stream into the key, erase and write-vector
// units (W words each), then captures beta, ga and gw.
module accelerator_write_heads_sequencer
  import dnc_pkg::*;
#(
  parameter int unsigned DATA_SIZE    = 64,
  parameter int unsigned CONTROL_SIZE = 64
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  input  logic [DATA_SIZE-1:0] SIZE_W_IN,
  input  logic                 DATA_IN_ENABLE,
  input  logic [DATA_SIZE-1:0] DATA_IN,
  output logic                 DATA_IN_READY,
  output logic [DATA_SIZE-1:0] DATA_OUT,
  output logic                 K_START,
  output logic                 E_START,
  output logic                 V_START,
  output logic                 K_IN_ENABLE,
  output logic                 E_IN_ENABLE,
  output logic                 V_IN_ENABLE,
  input  logic                 K_READY,
  input  logic                 E_READY,
  input  logic                 V_READY,
  output logic [DATA_SIZE-1:0] BETA_OUT,
  output logic [DATA_SIZE-1:0] GA_OUT,
  output logic [DATA_SIZE-1:0] GW_OUT,
  output logic                 SCALAR_OUT_ENABLE
);

  state_t r_state;
  state_t w_next_state;

  logic [DATA_SIZE-1:0]    r_size;
  logic [DATA_SIZE-1:0]    r_data_out;
  logic [DATA_SIZE-1:0]    r_beta;
  logic [DATA_SIZE-1:0]    r_ga;
  logic [DATA_SIZE-1:0]    r_gw;
  logic                    r_din_ready;
  logic                    r_ready;
  logic                    r_scalar_en;
  logic                    r_k_start;
  logic                    r_e_start;
  logic                    r_v_start;
  logic                    r_k_en;
  logic                    r_e_en;
  logic                    r_v_en;

  logic                    w_xfer;
  logic                    w_fwd;
  logic                    w_cnt_clear;
  logic                    w_cnt_inc;
  logic                    w_last;
  logic [CONTROL_SIZE-1:0] w_count;
  logic [CONTROL_SIZE-1:0] w_limit;
  logic                    w_k_start;
  logic                    w_e_start;
  logic                    w_v_start;
  logic                    w_ready;
  logic                    w_din_ready;

  assign w_xfer = DATA_IN_ENABLE & r_din_ready;
  assign w_fwd  = w_xfer & ((r_state == K_LOAD) | (r_state == E_LOAD) | (r_state == V_LOAD));

  // The scalar phase reuses the element counter with a fixed limit of GW_IDX.
  assign w_limit = (r_state == S_LOAD) ? CONTROL_SIZE'(GW_IDX)
                                       : CONTROL_SIZE'(r_size) - CONTROL_SIZE'(ONE_CONTROL);

  accelerator_vector_phase_counter #(
    .CONTROL_SIZE(CONTROL_SIZE)
  ) u_phase_counter (
    .i_clk  (CLK),
    .i_rst_n(RST),
    .i_clear(w_cnt_clear),
    .i_inc  (w_cnt_inc),
    .i_limit(w_limit),
    .o_count(w_count),
    .o_last (w_last)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_cnt_clear  = 1'b0;
    w_cnt_inc    = 1'b0;
    w_k_start    = 1'b0;
    w_e_start    = 1'b0;
    w_v_start    = 1'b0;
    w_ready      = 1'b0;
    case (r_state)
      IDLE: begin
        if (START) begin
          w_cnt_clear = 1'b1;
          if (SIZE_W_IN == DATA_SIZE'(ZERO_DATA)) begin
            w_next_state = S_LOAD;
          end else begin
            w_next_state = K_LOAD;
            w_k_start    = 1'b1;
          end
        end
      end
      K_LOAD, E_LOAD, V_LOAD: begin
        if (w_xfer) begin
          if (w_last) begin
            w_cnt_clear = 1'b1;
            if (r_state == K_LOAD)      w_next_state = K_WAIT;
            else if (r_state == E_LOAD) w_next_state = E_WAIT;
            else                        w_next_state = V_WAIT;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
      end
      K_WAIT: begin
        if (K_READY) begin
          w_e_start    = 1'b1;
          w_next_state = E_LOAD;
        end
      end
      E_WAIT: begin
        if (E_READY) begin
          w_v_start    = 1'b1;
          w_next_state = V_LOAD;
        end
      end
      V_WAIT: begin
        if (V_READY) begin
          w_next_state = S_LOAD;
        end
      end
      S_LOAD: begin
        // READY is shown while still in S_LOAD so a START cannot collide with it.
        if (r_ready) begin
          w_next_state = IDLE;
        end else if (w_xfer) begin
          if (w_last) begin
            w_cnt_clear = 1'b1;
            w_ready     = 1'b1;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
    w_din_ready = is_load(w_next_state) & ~w_ready;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_size      <= '0;
      r_data_out  <= '0;
      r_beta      <= '0;
      r_ga        <= '0;
      r_gw        <= '0;
      r_din_ready <= 1'b0;
      r_ready     <= 1'b0;
      r_scalar_en <= 1'b0;
      r_k_start   <= 1'b0;
      r_e_start   <= 1'b0;
      r_v_start   <= 1'b0;
      r_k_en      <= 1'b0;
      r_e_en      <= 1'b0;
      r_v_en      <= 1'b0;
    end else begin
      r_din_ready <= w_din_ready;
      r_ready     <= w_ready;
      r_scalar_en <= w_ready;
      r_k_start   <= w_k_start;
      r_e_start   <= w_e_start;
      r_v_start   <= w_v_start;
      r_k_en      <= w_fwd & (r_state == K_LOAD);
      r_e_en      <= w_fwd & (r_state == E_LOAD);
      r_v_en      <= w_fwd & (r_state == V_LOAD);
      if (w_fwd) begin
        r_data_out <= DATA_IN;
      end
      if (w_xfer && (r_state == S_LOAD)) begin
        if (w_count == CONTROL_SIZE'(BETA_IDX))    r_beta <= DATA_IN;
        else if (w_count == CONTROL_SIZE'(GA_IDX)) r_ga   <= DATA_IN;
        else                                       r_gw   <= DATA_IN;
      end
      if ((r_state == IDLE) && START) begin
        r_size <= SIZE_W_IN;
      end
    end
  end

  assign READY             = r_ready;
  assign DATA_IN_READY     = r_din_ready;
  assign DATA_OUT          = r_data_out;
  assign K_START           = r_k_start;
  assign E_START           = r_e_start;
  assign V_START           = r_v_start;
  assign K_IN_ENABLE       = r_k_en;
  assign E_IN_ENABLE       = r_e_en;
  assign V_IN_ENABLE       = r_v_en;
  assign BETA_OUT          = r_beta;
  assign GA_OUT            = r_ga;
  assign GW_OUT            = r_gw;
  assign SCALAR_OUT_ENABLE = r_scalar_en;

endmodule
